// File: rtl/zbt_pixel_packer_pkg.sv
// Shared ZBT pixel-pair definitions: widths, packer FSM encodings, 24->18 bit colour truncation.
// Also used by the reader-side debug logic.
package zbt_pixel_packer_pkg;

    localparam int PIX18_W    = 18;
    localparam int ZBT_DATA_W = 36;

    localparam logic [0:0] ST_EMPTY   = 1'b0;
    localparam logic [0:0] ST_HAVE_HI = 1'b1;

    // Keep the top six bits of each channel: {R[7:2],G[7:2],B[7:2]}
    function automatic logic [PIX18_W-1:0] rgb24_to_18(input logic [23:0] rgb);
        return {rgb[23:18], rgb[15:10], rgb[7:2]};
    endfunction

endpackage

// File: rtl/zbt_pixel_packer_if.sv
// Pixel input and ZBT write-side signals of the pixel packer.
// orphan_count exists only when ZBT_PACK_ERRCNT_EN is defined.
interface zbt_pixel_packer_if #(
    parameter int ADDR_W = 19
);
    import zbt_pixel_packer_pkg::*;

    logic [23:0]           pixel;
    logic                  pixel_valid;
    logic [10:0]           hcount;
    logic [9:0]            vcount;
    logic [ADDR_W-1:0]     zbt_addr;
    logic                  zbt_we;
    logic [ZBT_DATA_W-1:0] zbt_data;
    logic                  frame_done;
`ifdef ZBT_PACK_ERRCNT_EN
    logic [15:0]           orphan_count;
`endif

    modport master (
        output pixel, pixel_valid, hcount, vcount,
        input  zbt_addr, zbt_we, zbt_data, frame_done
`ifdef ZBT_PACK_ERRCNT_EN
        , input orphan_count
`endif
    );

    modport slave (
        input  pixel, pixel_valid, hcount, vcount,
        output zbt_addr, zbt_we, zbt_data, frame_done
`ifdef ZBT_PACK_ERRCNT_EN
        , output orphan_count
`endif
    );

endinterface

// File: rtl/zbt_wdata_delay.sv
// Two-stage write-data lag matching the ZBT write-data timing.
// Latency 2 cycles; free-running shift, never stalls; reset drops in-flight words.
module zbt_wdata_delay
    import zbt_pixel_packer_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ZBT_DATA_W-1:0] wr_dat,
    output logic [ZBT_DATA_W-1:0] lag_dat
);

    logic [ZBT_DATA_W-1:0] stage_dat;

    always_ff @(posedge clock) begin
        if (reset) begin
            stage_dat <= '0;
            lag_dat   <= '0;
        end else begin
            stage_dat <= wr_dat;
            lag_dat   <= stage_dat;
        end
    end

endmodule

// File: rtl/zbt_pixel_packer.sv
// Packs two adjacent 18-bit pixels per 36-bit ZBT word; orphan halves written zero-padded.
// Latency: we/addr 1 cycle after completing pixel, data 2 cycles after we; no backpressure.
// Optional ZBT_PACK_ERRCNT_EN adds a saturating orphan/flush counter.
module zbt_pixel_packer
    import zbt_pixel_packer_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19
) (
    input  logic              clock,
    input  logic              reset,
    zbt_pixel_packer_if.slave bus
);

    localparam logic [10:0] H_LIM    = 11'(H_ACTIVE);
    localparam logic [9:0]  V_LIM    = 10'(V_ACTIVE);
    localparam logic [9:0]  V_LAST   = 10'(V_ACTIVE - 1);
    localparam logic [9:0]  H_LAST_W = 10'((H_ACTIVE - 1) >> 1);

    logic [0:0]            state;
    logic [PIX18_W-1:0]    hi_q;
    logic [10:0]           held_h;
    logic [9:0]            held_v;
    logic                  held_odd;

    logic                  px_ok;
    logic [PIX18_W-1:0]    px18;
    logic                  adjacent;

    logic                  wr_go;
    logic                  wr_last;
    logic [ZBT_DATA_W-1:0] wr_data;
    logic [10:0]           wr_h;
    logic [9:0]            wr_v;
    logic                  latch;
    logic                  orphan_ev;
    logic [0:0]            nxt_state;

    logic [ADDR_W-1:0]     addr_q;
    logic                  we_q;
    logic                  last_q;
    logic                  done_q;
    logic [ZBT_DATA_W-1:0] wd_q;
    logic [ZBT_DATA_W-1:0] lag_dat;

    assign px_ok = bus.pixel_valid && (bus.hcount < H_LIM) && (bus.vcount < V_LIM);
    assign px18  = rgb24_to_18(bus.pixel);

    // A held odd pixel can never be the high half, so it is never completed by a neighbour
    assign adjacent = !held_odd && bus.hcount[0] && (bus.vcount == held_v) &&
                      (bus.hcount == held_h + 11'd1);

    always_comb begin
        wr_go     = 1'b0;
        wr_data   = '0;
        wr_h      = held_h;
        wr_v      = held_v;
        latch     = 1'b0;
        orphan_ev = 1'b0;
        nxt_state = state;
        if (px_ok) begin
            if (state == ST_EMPTY) begin
                if (bus.hcount[0]) begin
                    wr_go     = 1'b1;
                    wr_data   = {{PIX18_W{1'b0}}, px18};
                    wr_h      = bus.hcount;
                    wr_v      = bus.vcount;
                    orphan_ev = 1'b1;
                end else begin
                    latch     = 1'b1;
                    nxt_state = ST_HAVE_HI;
                end
            end else if (adjacent) begin
                wr_go     = 1'b1;
                wr_data   = {hi_q, px18};
                nxt_state = ST_EMPTY;
            end else begin
                // Flush the held half at its own address and adopt the new pixel
                wr_go     = 1'b1;
                wr_data   = held_odd ? {{PIX18_W{1'b0}}, hi_q} : {hi_q, {PIX18_W{1'b0}}};
                orphan_ev = 1'b1;
                latch     = 1'b1;
            end
        end
    end

    assign wr_last = (wr_v == V_LAST) && (wr_h[10:1] == H_LAST_W);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_EMPTY;
            hi_q     <= '0;
            held_h   <= '0;
            held_v   <= '0;
            held_odd <= 1'b0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
            wd_q     <= '0;
        end else begin
            state  <= nxt_state;
            we_q   <= wr_go;
            last_q <= wr_go && wr_last;
            done_q <= last_q;
            wd_q   <= wr_data;
            if (wr_go) begin
                addr_q <= ADDR_W'({wr_v[8:0], wr_h[10:1]});
            end
            if (latch) begin
                hi_q     <= px18;
                held_h   <= bus.hcount;
                held_v   <= bus.vcount;
                held_odd <= bus.hcount[0];
            end
        end
    end

    zbt_wdata_delay u_wdata_delay (
        .clock   (clock),
        .reset   (reset),
        .wr_dat  (wd_q),
        .lag_dat (lag_dat)
    );

    assign bus.zbt_we     = we_q;
    assign bus.zbt_addr   = addr_q;
    assign bus.zbt_data   = lag_dat;
    assign bus.frame_done = done_q;

`ifdef ZBT_PACK_ERRCNT_EN
    logic [15:0] orphan_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            orphan_cnt <= '0;
        end else if (orphan_ev && (orphan_cnt != 16'hFFFF)) begin
            orphan_cnt <= orphan_cnt + 16'd1;
        end
    end

    assign bus.orphan_count = orphan_cnt;
`endif

endmodule
